// File: rtl/audio_i2s_out_pkg.sv
// Shared audio definitions: sample width, I2S frame geometry and the
// signed 16-bit saturation used wherever two samples are summed.
package audio_i2s_out_pkg;

    localparam int AUDIO_SAMPLE_W = 16;
    localparam int I2S_SLOTS      = 32;

    typedef logic [AUDIO_SAMPLE_W-1:0] sample_t;

    // A 17-bit two's-complement sum overflows exactly when its top two bits differ.
    function automatic sample_t sat16(input logic [AUDIO_SAMPLE_W:0] sum);
        if (sum[AUDIO_SAMPLE_W] != sum[AUDIO_SAMPLE_W-1]) begin
            return sum[AUDIO_SAMPLE_W] ? 16'h8000 : 16'h7FFF;
        end
        return sum[AUDIO_SAMPLE_W-1:0];
    endfunction

endpackage

// File: rtl/audio_sat_add.sv
// Combinational signed 16+16 -> 16 adder that clamps to the sample range
// instead of wrapping.
module audio_sat_add
    import audio_i2s_out_pkg::*;
(
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] y
);

    logic [AUDIO_SAMPLE_W:0] sum;

    always_comb begin
        sum = {a[AUDIO_SAMPLE_W-1], a} + {b[AUDIO_SAMPLE_W-1], b};
        y   = sat16(sum);
    end

endmodule

// File: rtl/audio_i2s_out.sv
// PSG/PCM stereo mixer and Philips I2S serialiser; also produces the
// once-per-frame next_sample tick that paces the upstream sources.
module audio_i2s_out
    import audio_i2s_out_pkg::*;
#(
    parameter int CLKS_PER_HALF_BCK = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] psg_left,
    input  logic [15:0] psg_right,
    input  logic [15:0] pcm_left,
    input  logic [15:0] pcm_right,
    input  logic        mute,
    output logic        next_sample,
    output logic        i2s_bck,
    output logic        i2s_lrck,
    output logic        i2s_data
);

    localparam int DIV_MAX = 2 * CLKS_PER_HALF_BCK - 1;
    localparam int DIV_W   = $clog2(2 * CLKS_PER_HALF_BCK);

    logic [DIV_W-1:0] div_cnt;
    logic [DIV_W-1:0] div_next;
    logic [4:0]       slot_cnt;
    logic [4:0]       slot_next;
    logic [31:0]      shift_reg;
    logic [31:0]      shift_src;
    logic [31:0]      load_word;
    logic             delay_bit;
    logic             fall;
    logic             frame_start;
    logic             bck_next;
    sample_t          sum_l;
    sample_t          sum_r;

    audio_sat_add u_sat_l (
        .a (psg_left),
        .b (pcm_left),
        .y (sum_l)
    );

    audio_sat_add u_sat_r (
        .a (psg_right),
        .b (pcm_right),
        .y (sum_r)
    );

    // The frame-start load feeds the shifter in the same cycle, so the left
    // MSB lands in the delay bit immediately and reaches the pin one BCK later.
    always_comb begin
        fall        = (div_cnt == DIV_W'(DIV_MAX));
        div_next    = fall ? '0 : div_cnt + 1'b1;
        bck_next    = (div_next >= DIV_W'(CLKS_PER_HALF_BCK));
        slot_next   = slot_cnt + 5'd1;
        frame_start = fall && (slot_cnt == 5'(I2S_SLOTS - 1));
        load_word   = mute ? 32'h0 : {sum_l, sum_r};
        shift_src   = frame_start ? load_word : shift_reg;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt     <= '0;
            slot_cnt    <= '0;
            shift_reg   <= '0;
            delay_bit   <= 1'b0;
            next_sample <= 1'b0;
            i2s_bck     <= 1'b0;
            i2s_lrck    <= 1'b0;
            i2s_data    <= 1'b0;
        end else begin
            div_cnt     <= div_next;
            i2s_bck     <= bck_next;
            next_sample <= frame_start;
            if (fall) begin
                slot_cnt  <= slot_next;
                i2s_lrck  <= (slot_next >= 5'(I2S_SLOTS / 2));
                i2s_data  <= delay_bit;
                delay_bit <= shift_src[31];
                shift_reg <= {shift_src[30:0], 1'b0};
            end
        end
    end

endmodule

// File: tb/tb_audio_i2s_out.sv
// Directed bench for audio_i2s_out: frame timing, word capture, saturation,
// mute sampling and asynchronous reset, at the default and fastest BCK rates.
module tb_audio_i2s_out;

    logic        clk = 1'b0;
    logic        rst;
    logic        rst_f;
    logic [15:0] psg_left;
    logic [15:0] psg_right;
    logic [15:0] pcm_left;
    logic [15:0] pcm_right;
    logic        mute;

    logic ns_d, bck_d, lrck_d, data_d;
    logic ns_f, bck_f, lrck_f, data_f;

    logic use_fast = 1'b0;
    int   half = 8;
    int   checks = 0;
    int   failures = 0;

    logic sel_ns, sel_bck, sel_lrck, sel_data;

    always #5 clk = ~clk;

    audio_i2s_out dut (
        .clk         (clk),
        .rst         (rst),
        .psg_left    (psg_left),
        .psg_right   (psg_right),
        .pcm_left    (pcm_left),
        .pcm_right   (pcm_right),
        .mute        (mute),
        .next_sample (ns_d),
        .i2s_bck     (bck_d),
        .i2s_lrck    (lrck_d),
        .i2s_data    (data_d)
    );

    audio_i2s_out #(.CLKS_PER_HALF_BCK(2)) dut_fast (
        .clk         (clk),
        .rst         (rst_f),
        .psg_left    (psg_left),
        .psg_right   (psg_right),
        .pcm_left    (pcm_left),
        .pcm_right   (pcm_right),
        .mute        (mute),
        .next_sample (ns_f),
        .i2s_bck     (bck_f),
        .i2s_lrck    (lrck_f),
        .i2s_data    (data_f)
    );

    always_comb begin
        sel_ns   = use_fast ? ns_f   : ns_d;
        sel_bck  = use_fast ? bck_f  : bck_d;
        sel_lrck = use_fast ? lrck_f : lrck_d;
        sel_data = use_fast ? data_f : data_d;
    end

    task automatic check_output(input string tag, input logic [32:0] obs, input logic [32:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Counts negedges until next_sample is seen; optionally verifies the
    // BCK/LRCK waveform against the edge count since reset release.
    task automatic wait_pulse(input bit pattern, output int n);
        bit seen;
        int bad;
        seen = 1'b0;
        bad  = 0;
        n    = 0;
        while (!seen && n < 2000) begin
            @(negedge clk);
            n++;
            if (pattern) begin
                if (sel_bck !== ((n % (2 * half)) >= half)) bad++;
                if (sel_lrck !== (((n / (2 * half)) % 32) >= 16)) bad++;
            end
            if (sel_ns === 1'b1) seen = 1'b1;
        end
        check_output("pulse_seen", 33'(seen), 33'd1);
        if (pattern) check_output("bck_lrck_pattern", 33'(bad), 33'd0);
    endtask

    // Samples data and LRCK mid-slot for slots 0..31 plus slot 0 of the next frame.
    task automatic capture_frame(output logic [15:0] left, output logic [15:0] right,
                                 output logic [32:0] lr, output logic first_bit);
        logic [32:0] d;
        for (int s = 0; s < 33; s++) begin
            repeat (half) @(negedge clk);
            d[s]  = sel_data;
            lr[s] = sel_lrck;
            repeat (half) @(negedge clk);
        end
        for (int i = 0; i < 16; i++) begin
            left[15-i]  = d[1+i];
            right[15-i] = d[17+i];
        end
        first_bit = d[0];
    endtask

    task automatic apply_stimulus(input logic [15:0] pl, input logic [15:0] ql,
                                  input logic [15:0] pr, input logic [15:0] qr);
        psg_left  = pl;
        pcm_left  = ql;
        psg_right = pr;
        pcm_right = qr;
    endtask

    initial begin
        int          n;
        logic [15:0] l;
        logic [15:0] r;
        logic [32:0] lr;
        logic        b0;

        rst   = 1'b1;
        rst_f = 1'b1;
        mute  = 1'b0;
        apply_stimulus(16'h1234, 16'h0000, 16'h0000, 16'h00FF);
        repeat (3) @(negedge clk);
        check_output("reset_outputs", 33'({ns_d, bck_d, lrck_d, data_d}), 33'd0);
        check_output("reset_outputs_fast", 33'({ns_f, bck_f, lrck_f, data_f}), 33'd0);

        $display("[TB] default rate: timing after reset release");
        rst = 1'b0;
        wait_pulse(1'b1, n);
        check_output("first_pulse_edge", 33'(n), 33'd512);
        @(negedge clk);
        check_output("pulse_width", 33'(sel_ns), 33'd0);
        wait_pulse(1'b0, n);
        check_output("pulse_period", 33'(n + 1), 33'd512);

        capture_frame(l, r, lr, b0);
        check_output("left_word", 33'(l), 33'h1234);
        check_output("right_word", 33'(r), 33'h00FF);
        check_output("lrck_slots", lr, 33'h0FFFF0000);
        check_output("slot0_prev_lsb", 33'(b0), 33'd1);

        $display("[TB] saturation");
        apply_stimulus(16'h7000, 16'h2000, 16'h9000, 16'hA000);
        wait_pulse(1'b0, n);
        capture_frame(l, r, lr, b0);
        check_output("sat_pos_left", 33'(l), 33'h7FFF);
        check_output("sat_neg_right", 33'(r), 33'h8000);

        $display("[TB] mute handling");
        repeat (100) @(negedge clk);
        mute = 1'b1;
        @(negedge clk);
        mute = 1'b0;
        wait_pulse(1'b0, n);
        capture_frame(l, r, lr, b0);
        check_output("mute_glitch_left", 33'(l), 33'h7FFF);
        check_output("mute_glitch_right", 33'(r), 33'h8000);

        mute = 1'b1;
        wait_pulse(1'b0, n);
        capture_frame(l, r, lr, b0);
        check_output("muted_left", 33'(l), 33'h0000);
        check_output("muted_right", 33'(r), 33'h0000);
        mute = 1'b0;
        wait_pulse(1'b0, n);
        capture_frame(l, r, lr, b0);
        check_output("unmuted_left", 33'(l), 33'h7FFF);
        check_output("unmuted_right", 33'(r), 33'h8000);

        $display("[TB] reset mid-frame");
        wait_pulse(1'b0, n);
        repeat (20 * 2 * half + half) @(negedge clk);
        check_output("lrck_slot20", 33'(sel_lrck), 33'd1);
        check_output("bck_mid_slot20", 33'(sel_bck), 33'd1);
        #2 rst = 1'b1;
        #1 check_output("reset_async", 33'({ns_d, bck_d, lrck_d, data_d}), 33'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        wait_pulse(1'b1, n);
        check_output("restart_pulse_edge", 33'(n), 33'd512);

        $display("[TB] fast rate CLKS_PER_HALF_BCK=2");
        use_fast = 1'b1;
        half     = 2;
        apply_stimulus(16'h1234, 16'h0000, 16'h0000, 16'h00FF);
        @(negedge clk);
        rst_f = 1'b0;
        wait_pulse(1'b1, n);
        check_output("fast_first_pulse_edge", 33'(n), 33'd128);
        capture_frame(l, r, lr, b0);
        check_output("fast_left_word", 33'(l), 33'h1234);
        check_output("fast_right_word", 33'(r), 33'h00FF);
        check_output("fast_lrck_slots", lr, 33'h0FFFF0000);
        apply_stimulus(16'h7000, 16'h2000, 16'h9000, 16'hA000);
        wait_pulse(1'b0, n);
        capture_frame(l, r, lr, b0);
        check_output("fast_sat_left", 33'(l), 33'h7FFF);
        check_output("fast_sat_right", 33'(r), 33'h8000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
